// File: rtl/spi_ram_arbiter.sv
// Bridges the SPI slave's 10-bit command stream and a host port onto one single-port RAM.
// Round-robin arbitration with at most one access in flight; all RAM-side outputs are registered.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [7:0]           host_rdata,
  output logic                 spi_ovf,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACC_SPI, ACC_HOST, RD_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic                   rx_valid_d_reg, rx_valid_d_next;
  logic                   rx_armed_reg, rx_armed_next;
  logic [ADDR_SIZE-1:0]   wr_addr_reg, wr_addr_next;
  logic [ADDR_SIZE-1:0]   rd_addr_reg, rd_addr_next;
  logic                   spi_pend_reg, spi_pend_next;
  logic                   pend_we_reg, pend_we_next;
  logic [ADDR_SIZE-1:0]   pend_addr_reg, pend_addr_next;
  logic [7:0]             pend_data_reg, pend_data_next;
  logic                   spi_ovf_reg, spi_ovf_next;
  logic                   last_spi_reg, last_spi_next;
  logic [7:0]             tx_data_reg, tx_data_next;
  logic                   tx_valid_reg, tx_valid_next;
  logic [7:0]             host_rdata_reg, host_rdata_next;
  logic                   host_rvalid_reg, host_rvalid_next;
  logic                   host_gnt_reg, host_gnt_next;
  logic                   ram_en_reg, ram_en_next;
  logic                   ram_we_reg, ram_we_next;
  logic [ADDR_SIZE-1:0]   ram_addr_reg, ram_addr_next;
  logic [7:0]             ram_wdata_reg, ram_wdata_next;

  logic                   accept;
  logic                   grant_spi;
  logic                   grant_host;
  logic [ADDR_SIZE-1:0]   payload_addr;

  assign payload_addr = ADDR_SIZE'(rx_data[7:0]);

  always_comb begin
    state_next       = state_reg;
    rx_valid_d_next  = rx_valid;
    // A word already held high when reset releases must not look like a fresh edge.
    rx_armed_next    = rx_armed_reg | ~rx_valid;
    wr_addr_next     = wr_addr_reg;
    rd_addr_next     = rd_addr_reg;
    spi_pend_next    = spi_pend_reg;
    pend_we_next     = pend_we_reg;
    pend_addr_next   = pend_addr_reg;
    pend_data_next   = pend_data_reg;
    spi_ovf_next     = spi_ovf_reg;
    last_spi_next    = last_spi_reg;
    tx_data_next     = tx_data_reg;
    tx_valid_next    = tx_valid_reg;
    host_rdata_next  = host_rdata_reg;
    host_rvalid_next = 1'b0;
    host_gnt_next    = 1'b0;
    ram_en_next      = 1'b0;
    ram_we_next      = 1'b0;
    ram_addr_next    = ram_addr_reg;
    ram_wdata_next   = ram_wdata_reg;
    grant_spi        = 1'b0;
    grant_host       = 1'b0;
    accept           = rx_valid & ~rx_valid_d_reg & rx_armed_reg;

    case (state_reg)
      IDLE: begin
        if (spi_pend_reg && host_req) begin
          grant_host = last_spi_reg;
          grant_spi  = ~last_spi_reg;
        end else begin
          grant_spi  = spi_pend_reg;
          grant_host = host_req;
        end
      end
      ACC_SPI, ACC_HOST: state_next = ram_we_reg ? IDLE : RD_WAIT;
      RD_WAIT: begin
        state_next = IDLE;
        // last_spi was loaded with the owner when this access was granted.
        if (last_spi_reg) begin
          tx_data_next  = ram_rdata;
          tx_valid_next = 1'b1;
        end else begin
          host_rdata_next  = ram_rdata;
          host_rvalid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (grant_spi) begin
      state_next     = ACC_SPI;
      ram_en_next    = 1'b1;
      ram_we_next    = pend_we_reg;
      ram_addr_next  = pend_addr_reg;
      ram_wdata_next = pend_data_reg;
      last_spi_next  = 1'b1;
      spi_pend_next  = 1'b0;
    end else if (grant_host) begin
      state_next     = ACC_HOST;
      ram_en_next    = 1'b1;
      ram_we_next    = host_we;
      ram_addr_next  = host_addr;
      ram_wdata_next = host_wdata;
      last_spi_next  = 1'b0;
      host_gnt_next  = 1'b1;
    end

    // Decoded after arbitration so a word accepted this cycle re-arms spi_pend.
    if (accept) begin
      case (rx_data[9:8])
        2'b00: wr_addr_next = payload_addr;
        2'b10: rd_addr_next = payload_addr;
        2'b01: begin
          if (spi_pend_reg && !grant_spi) spi_ovf_next = 1'b1;
          spi_pend_next  = 1'b1;
          pend_we_next   = 1'b1;
          pend_addr_next = wr_addr_reg;
          pend_data_next = rx_data[7:0];
        end
        2'b11: begin
          if (spi_pend_reg && !grant_spi) spi_ovf_next = 1'b1;
          spi_pend_next  = 1'b1;
          pend_we_next   = 1'b0;
          pend_addr_next = rd_addr_reg;
          tx_valid_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      rx_valid_d_reg  <= 1'b0;
      rx_armed_reg    <= 1'b0;
      wr_addr_reg     <= '0;
      rd_addr_reg     <= '0;
      spi_pend_reg    <= 1'b0;
      pend_we_reg     <= 1'b0;
      pend_addr_reg   <= '0;
      pend_data_reg   <= 8'h00;
      spi_ovf_reg     <= 1'b0;
      last_spi_reg    <= 1'b0;
      tx_data_reg     <= 8'h00;
      tx_valid_reg    <= 1'b0;
      host_rdata_reg  <= 8'h00;
      host_rvalid_reg <= 1'b0;
      host_gnt_reg    <= 1'b0;
      ram_en_reg      <= 1'b0;
      ram_we_reg      <= 1'b0;
      ram_addr_reg    <= '0;
      ram_wdata_reg   <= 8'h00;
    end else begin
      state_reg       <= state_next;
      rx_valid_d_reg  <= rx_valid_d_next;
      rx_armed_reg    <= rx_armed_next;
      wr_addr_reg     <= wr_addr_next;
      rd_addr_reg     <= rd_addr_next;
      spi_pend_reg    <= spi_pend_next;
      pend_we_reg     <= pend_we_next;
      pend_addr_reg   <= pend_addr_next;
      pend_data_reg   <= pend_data_next;
      spi_ovf_reg     <= spi_ovf_next;
      last_spi_reg    <= last_spi_next;
      tx_data_reg     <= tx_data_next;
      tx_valid_reg    <= tx_valid_next;
      host_rdata_reg  <= host_rdata_next;
      host_rvalid_reg <= host_rvalid_next;
      host_gnt_reg    <= host_gnt_next;
      ram_en_reg      <= ram_en_next;
      ram_we_reg      <= ram_we_next;
      ram_addr_reg    <= ram_addr_next;
      ram_wdata_reg   <= ram_wdata_next;
    end
  end

  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign host_gnt    = host_gnt_reg;
  assign host_rvalid = host_rvalid_reg;
  assign host_rdata  = host_rdata_reg;
  assign spi_ovf     = spi_ovf_reg;
  assign ram_en      = ram_en_reg;
  assign ram_we      = ram_we_reg;
  assign ram_addr    = ram_addr_reg;
  assign ram_wdata   = ram_wdata_reg;

endmodule
